// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the 16-bit instruction memory.
// Optional trailing checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [7:0]  BASE_ADDR    = 8'd0,
  parameter int unsigned IDLE_TIMEOUT = 1000
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_CSUM
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    hi_q, hi_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  logic acc;
  logic timeout;

  assign rx_ready = ~clear;
  assign acc      = rx_valid & rx_ready;
  assign timeout  = (state_q != S_IDLE) && !acc && (idle_q == TO_LAST);

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign error    = err_q;

  // Frame parser: next state, counters and registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    hi_d      = hi_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    err_d     = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    idle_d    = (state_q == S_IDLE || acc) ? '0 : idle_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (acc && rx_data == 8'hA5) begin
          state_d = S_COUNT;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      S_COUNT: begin
        if (acc) begin
          cnt_d   = {(rx_data == 8'd0), rx_data};
          addr_d  = BASE_ADDR;
          state_d = S_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      S_HI: begin
        if (acc) begin
          hi_d    = rx_data;
          state_d = S_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + rx_data;
`endif
        end
      end
      S_LO: begin
        if (acc) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {hi_q, rx_data};
          addr_d    = addr_q + 8'd1;
          cnt_d     = cnt_q - 9'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d     = sum_q + rx_data;
`endif
          if (cnt_q == 9'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
`endif
          end else begin
            state_d = S_HI;
          end
        end
      end
      S_CSUM: begin
        if (acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (rx_data == sum_q) done_d = 1'b1;
          else                  err_d  = 1'b1;
`endif
          hold_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      hold_d  = 1'b0;
    end
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= BASE_ADDR;
      hi_q      <= '0;
      idle_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= '0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      idle_q    <= idle_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed table, corner sequences and random frames
// checked against a byte-position reference model of the frame protocol.
module tb_imem_loader;

  localparam logic [7:0] BASE = 8'hFE;
  localparam int         TO   = 10;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        v   = 1'b0;
  logic [7:0]  d   = 8'h00;
  logic        rx_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader #(.BASE_ADDR(BASE), .IDLE_TIMEOUT(TO)) dut (
    .clock   (clk),
    .clear   (clr),
    .rx_data (d),
    .rx_valid(v),
    .rx_ready(rx_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int nwr    = 0;
  int ndone  = 0;
  logic [7:0]  lw_addr;
  logic [15:0] lw_data;
  logic [7:0]  wq[$];

  // reference model: frame position arithmetic
  bit          m_in;
  int          m_pos, m_n, m_gap;
  logic [7:0]  m_sum, m_wa, m_hi;
  bit          e_wen, e_hold, e_done, e_err;
  logic [7:0]  e_addr;
  logic [15:0] e_data;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  task automatic model(bit c, bit vv, logic [7:0] dd);
    e_wen  = 1'b0;
    e_done = 1'b0;
    if (c) begin
      m_in = 1'b0; e_addr = BASE; e_data = 16'h0;
      e_hold = 1'b0; e_err = 1'b0;
      return;
    end
    if (!m_in) begin
      if (vv && dd == 8'hA5) begin
        m_in = 1'b1; m_pos = 0; m_gap = 0;
        e_err = 1'b0; e_hold = 1'b1;
      end
      return;
    end
    if (!vv) begin
      m_gap++;
      if (m_gap == TO) begin
        m_in = 1'b0; e_err = 1'b1; e_hold = 1'b0;
      end
      return;
    end
    m_gap = 0;
    m_pos++;
    if (m_pos == 1) begin
      m_n   = (dd == 8'h00) ? 256 : int'(dd);
      m_sum = 8'h00;
      m_wa  = BASE;
    end else if (m_pos <= 2 * m_n + 1) begin
      m_sum = m_sum + dd;
      if (m_pos % 2 == 0) m_hi = dd;
      else begin
        e_wen  = 1'b1;
        e_addr = m_wa;
        e_data = {m_hi, dd};
        m_wa   = m_wa + 8'd1;
        if (m_pos == 2 * m_n + 1 && !CS) begin
          e_done = 1'b1; e_hold = 1'b0; m_in = 1'b0;
        end
      end
    end else begin
      if (dd == m_sum) e_done = 1'b1;
      else             e_err  = 1'b1;
      e_hold = 1'b0;
      m_in   = 1'b0;
    end
  endtask

  task automatic step(bit c, bit vv, logic [7:0] dd);
    @(negedge clk);
    clr = c; v = vv; d = dd;
    @(posedge clk);
    model(c, vv, dd);
    #1;
    cyc++;
    chk("cycle_outputs",
        {rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error},
        {!c, e_wen, e_addr, e_data, e_hold, e_done, e_err});
    if (wr_en) begin
      wq.push_back(wr_addr);
      lw_addr = wr_addr;
      lw_data = wr_data;
      nwr++;
    end
    if (done) ndone++;
  endtask

  task automatic sendb(logic [7:0] b);
    int r, g;
    r = $urandom_range(0, 99);
    g = (r < 85) ? 0 : (r < 97) ? $urandom_range(1, 3) : TO + 2;
    repeat (g) step(1'b0, 1'b0, 8'($urandom));
    if ($urandom_range(0, 199) == 0) step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, b);
  endtask

  typedef struct {
    bit          c;
    bit          v;
    logic [7:0]  d;
    bit          wen;
    logic [7:0]  a;
    logic [15:0] wd;
    bit          h;
    bit          dn;
    bit          er;
  } vec_t;

  vec_t        tbl[10];
  int          nw0, nd0, k, n;
  logic [7:0]  s, b;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, BASE,  16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b0, BASE,  16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'hA5, 1'b0, BASE,  16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'h02, 1'b0, BASE,  16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h21, 1'b0, BASE,  16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'h23, 1'b1, 8'hFE, 16'h2123, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 8'h61, 1'b0, 8'hFE, 16'h2123, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 8'h23, 1'b1, 8'hFF, 16'h6123, CS, !CS, 1'b0};
    tbl[8] = '{1'b0, CS,   8'hC8, 1'b0, 8'hFF, 16'h6123, 1'b0, CS, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 16'h6123, 1'b0, 1'b0, 1'b0};

    // reset then idle
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("reset_state", {rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error},
        {1'b0, 1'b0, BASE, 16'h0, 1'b0, 1'b0, 1'b0});
    nw0 = nwr;
    repeat (20) step(1'b0, 1'b0, 8'h00);
    chk("idle_no_write", nwr - nw0, 0);
    chk("idle_ready", rx_ready, 1'b1);

    // nominal 2-word frame from the table
    nw0 = nwr; nd0 = ndone;
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].c, tbl[i].v, tbl[i].d);
      chk("table_vec", {wr_en, wr_addr, wr_data, cpu_hold, done, error},
          {tbl[i].wen, tbl[i].a, tbl[i].wd, tbl[i].h, tbl[i].dn, tbl[i].er});
    end
    chk("nominal_writes", nwr - nw0, 2);
    chk("nominal_done_once", ndone - nd0, 1);

    // checksum mismatch
    nw0 = nwr; nd0 = ndone;
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'hF0);
    step(1'b0, 1'b1, 8'h03);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("mismatch_write", {lw_addr, lw_data}, {8'hFE, 16'hF003});
    chk("mismatch_nwr", nwr - nw0, 1);
    chk("mismatch_error", error, CS);
    chk("mismatch_done", ndone - nd0, !CS);
    chk("mismatch_hold", cpu_hold, 1'b0);

    // address wrap FE FF 00
    wq.delete();
    nd0 = ndone;
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h03);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 8'(i));
    end
    step(1'b0, 1'b1, 8'h06);
    step(1'b0, 1'b0, 8'h00);
    chk("wrap_count", wq.size(), 3);
    chk("wrap_addr0", wq[0], 8'hFE);
    chk("wrap_addr1", wq[1], 8'hFF);
    chk("wrap_addr2", wq[2], 8'h00);
    chk("wrap_done", ndone - nd0, 1);
    chk("wrap_error", error, 1'b0);

    // timeout
    nw0 = nwr;
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h12);
    k = 0;
    while (k < 3 * TO && !error) begin
      step(1'b0, 1'b0, 8'h00);
      k++;
    end
    chk("timeout_cycles", k, TO);
    chk("timeout_hold", cpu_hold, 1'b0);
    chk("timeout_nowrite", nwr - nw0, 0);

    // garbage then clear mid-frame
    nw0 = nwr;
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    chk("garbage_ignored", cpu_hold, 1'b0);
    step(1'b0, 1'b1, 8'hA5);
    chk("header_clears_error", {cpu_hold, error}, {1'b1, 1'b0});
    step(1'b0, 1'b1, 8'h03);
    step(1'b0, 1'b1, 8'h11);
    step(1'b1, 1'b1, 8'h22);
    chk("clear_outputs", {rx_ready, wr_en, cpu_hold, done, error}, 5'b00000);
    step(1'b0, 1'b1, 8'h22);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    chk("clear_no_write", nwr - nw0, 0);
    chk("clear_idle_hold", cpu_hold, 1'b0);

    // random frames
    for (int f = 0; f < 150; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        sendb(b);
      end
      n = ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 5);
      sendb(8'hA5);
      sendb(8'(n));
      s = 8'h00;
      for (int w = 0; w < ((n == 0) ? 512 : 2 * n); w++) begin
        b = 8'($urandom);
        s = s + b;
        sendb(b);
      end
      if (CS) sendb(($urandom_range(0, 9) < 7) ? s : s ^ 8'h5A);
      repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 8'h00);
    end
    repeat (TO + 2) step(1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
